// File: rtl/pipelined_rca_pkg.sv
// Shared elaboration helpers for the pipelined ripple-carry adder.
package pipelined_rca_pkg;

  function automatic int unsigned calc_nstages(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 0 : width / chunk;
  endfunction

  function automatic bit width_ok(input int unsigned width, input int unsigned chunk);
    return (chunk != 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple adder built from full_adder cells.
module rca_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  // Carry lives per bit-slice so the chain is a set of distinct nets.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_next
      assign ci = g_bit[i-1].co;
    end
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (ci),
      .sum  (sum[i]),
      .cout (co)
    );
  end

  assign cout = g_bit[CHUNK-1].co;

endmodule

// File: rtl/pipelined_rca.sv
// Elastic pipelined ripple-carry adder/subtractor: one CHUNK-bit ripple per
// register stage, valid/ready on both sides, one beat per clock.
module pipelined_rca
  import pipelined_rca_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSTAGES = calc_nstages(WIDTH, CHUNK);
  localparam int unsigned LAST    = NSTAGES - 1;

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("pipelined_rca: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic [WIDTH-1:0] eff_b;
  logic             carry0;

  assign eff_b  = sub ? ~b : b;
  assign carry0 = sub | cin;

  // Stage k holds resolved sum bits [SW-1:0], the carry into chunk k+1 and
  // only the operand bits that later stages still need.
  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int unsigned LO = k * CHUNK;
    localparam int unsigned UW = WIDTH - LO;
    localparam int unsigned SW = LO + CHUNK;

    logic          up_v;
    logic          up_c;
    logic [UW-1:0] up_a;
    logic [UW-1:0] up_b;
    logic [CHUNK-1:0] ch_s;
    logic          ch_c;
    logic [SW-1:0] nxt_s;
    logic          rdy;
    logic          v_q;
    logic          c_q;
    logic [SW-1:0] s_q;

    if (k == 0) begin : g_head
      assign up_v  = in_valid;
      assign up_a  = a;
      assign up_b  = eff_b;
      assign up_c  = carry0;
      assign nxt_s = ch_s;
    end else begin : g_link
      assign up_v  = g_stage[k-1].v_q;
      assign up_a  = g_stage[k-1].g_fwd.fa_q;
      assign up_b  = g_stage[k-1].g_fwd.fb_q;
      assign up_c  = g_stage[k-1].c_q;
      assign nxt_s = {ch_s, g_stage[k-1].s_q};
    end

    rca_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (up_a[CHUNK-1:0]),
      .b    (up_b[CHUNK-1:0]),
      .cin  (up_c),
      .sum  (ch_s),
      .cout (ch_c)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (rdy) begin
        v_q <= up_v;
        if (up_v) begin
          c_q <= ch_c;
          s_q <= nxt_s;
        end
      end
    end

    if (k < NSTAGES - 1) begin : g_fwd
      localparam int unsigned FW = UW - CHUNK;
      logic [FW-1:0] fa_q;
      logic [FW-1:0] fb_q;

      assign rdy = !v_q || g_stage[k+1].rdy;

      always_ff @(posedge clk) begin
        if (rst) begin
          fa_q <= '0;
          fb_q <= '0;
        end else if (rdy && up_v) begin
          fa_q <= up_a[UW-1:CHUNK];
          fb_q <= up_b[UW-1:CHUNK];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      assign rdy = !v_q || out_ready;

      // Sign bits of a and effective b are the top operand bits reaching this stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (rdy && up_v) begin
          ovf_q <= (up_a[UW-1] == up_b[UW-1]) && (nxt_s[SW-1] != up_a[UW-1]);
        end
      end
    end
  end

  assign in_ready  = g_stage[0].rdy;
  assign out_valid = g_stage[LAST].v_q;
  assign sum       = g_stage[LAST].s_q;
  assign cout      = g_stage[LAST].c_q;
  assign ovf       = g_stage[LAST].g_tail.ovf_q;

endmodule
